spi_mem_target: RTL and testbench

- SPI mode-0 target (responder) that answers the SoC memory controller's serial READ (0x03) and WRITE (0x02) commands.
- Used as an on-chip or FPGA-side SPI RAM/Flash stand-in; sits on the far end of the shared sclk/mosi/miso bus behind one chip-select.
- Decodes command and 24-bit address, then streams bytes to/from a byte-wide synchronous memory port with address auto-increment.
- All SPI inputs are oversampled in the clk domain.

---
 rtl/spi_mem_target.sv | 192 +++++++++++++++++++
 tb/tb_spi_mem_target.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_target.sv
// spi_mem_target: SPI mode-0 target answering READ (0x03) and WRITE (0x02)
// commands against a byte-wide synchronous memory port, with address
// auto-increment that wraps modulo 2**MEM_AW.
//
// Optional build macro: SPI_TGT_FAST_READ_EN -- accept FAST READ (0x0B), which
// inserts 8 dummy sclk cycles between the address and the first data byte.
//
// Ports:
//   clk, rst_n        system clock (>= 4x sclk), synchronous active-low reset
//   spi_cs_n          chip select, active low
//   spi_sclk          SPI clock, idle low
//   spi_mosi          serial data in, MSB first
//   spi_miso          serial data out, MSB first (holds value when not driving)
//   spi_miso_oe       miso drive enable for the shared bus
//   mem_addr          memory byte address (low MEM_AW bits of the SPI address)
//   mem_wdata         memory write data
//   mem_we            one-cycle write strobe (never asserted when READ_ONLY=1)
//   mem_re            one-cycle read strobe
//   mem_rdata         read data, valid 1 clk after mem_re
//   busy              high while synchronized chip select is low
module spi_mem_target #(
   parameter int unsigned MEM_AW    = 16,
   parameter int unsigned READ_ONLY = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              spi_cs_n,
   input  logic              spi_sclk,
   input  logic              spi_mosi,
   output logic              spi_miso,
   output logic              spi_miso_oe,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [7:0]        mem_rdata,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE, CMD, ADDR, DUMMY, RDATA, WDATA, IGNORE
   } state_t;

   state_t state, state_nx;

   logic [1:0] cs_sync, sclk_sync, mosi_sync;
   logic       cs_s, sclk_s, mosi_s, sclk_prev, cs_prev;
   logic       sclk_rise, sclk_fall, cs_fall, last_rise;
   logic       cmd_rd, cmd_wr, fast_ok;

   logic [4:0]        bit_cnt;
   // Only the low MEM_AW address bits are kept; upper bits shift out the top.
   logic [MEM_AW-2:0] shift_in;
   logic [MEM_AW-1:0] shift_nx;
   logic [MEM_AW-1:0] addr;
   logic [7:0]        tx_sr, byte_cur, wdata_r;
   logic              rd_flag, fast_flag, re_r, cap_pend, wr_step, oe_r, miso_r;

   // Input synchronizers and edge detectors
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cs_sync   <= '1;
         sclk_sync <= '0;
         mosi_sync <= '0;
         sclk_prev <= 1'b0;
         cs_prev   <= 1'b1;
      end else begin
         cs_sync   <= {cs_sync[0], spi_cs_n};
         sclk_sync <= {sclk_sync[0], spi_sclk};
         mosi_sync <= {mosi_sync[0], spi_mosi};
         sclk_prev <= sclk_sync[1];
         cs_prev   <= cs_sync[1];
      end
   end

   assign cs_s      = cs_sync[1];
   assign sclk_s    = sclk_sync[1];
   assign mosi_s    = mosi_sync[1];
   assign sclk_rise = sclk_s & ~sclk_prev & ~cs_s;
   assign sclk_fall = ~sclk_s & sclk_prev & ~cs_s;
   assign cs_fall   = cs_prev & ~cs_s;
   assign shift_nx  = {shift_in, mosi_s};
   assign last_rise = sclk_rise & ((state == ADDR) ? (bit_cnt == 5'd23) : (bit_cnt == 5'd7));
   assign cmd_rd    = (shift_nx[7:0] == 8'h03);
   assign cmd_wr    = (shift_nx[7:0] == 8'h02);
`ifdef SPI_TGT_FAST_READ_EN
   assign fast_ok   = (shift_nx[7:0] == 8'h0B);
`else
   assign fast_ok   = 1'b0;
`endif

   // A fetched byte may land in the same cycle as the fall that needs its MSB.
   assign byte_cur = cap_pend ? mem_rdata : tx_sr;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      if (cs_s) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE:  if (cs_fall) state_nx = CMD;
            CMD:   if (last_rise) state_nx = (cmd_rd | cmd_wr | fast_ok) ? ADDR : IGNORE;
            ADDR:  if (last_rise) state_nx = fast_flag ? DUMMY : (rd_flag ? RDATA : WDATA);
            DUMMY: if (last_rise) state_nx = RDATA;
            default: ;
         endcase
      end
   end

   // Datapath: shifting, address, memory strobes, transmit register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt   <= '0;
         shift_in  <= '0;
         addr      <= '0;
         tx_sr     <= '0;
         wdata_r   <= '0;
         rd_flag   <= 1'b0;
         fast_flag <= 1'b0;
         re_r      <= 1'b0;
         cap_pend  <= 1'b0;
         wr_step   <= 1'b0;
         oe_r      <= 1'b0;
         miso_r    <= 1'b0;
      end else begin
         re_r     <= 1'b0;
         wr_step  <= 1'b0;
         cap_pend <= re_r;
         if (cs_s) begin
            // Deselect drops partial bytes and any read still in flight.
            bit_cnt  <= '0;
            oe_r     <= 1'b0;
            cap_pend <= 1'b0;
         end else begin
            if (state == IDLE)  bit_cnt <= '0;
            else if (sclk_rise) bit_cnt <= last_rise ? 5'd0 : bit_cnt + 5'd1;

            if (sclk_rise) shift_in <= shift_nx[MEM_AW-2:0];

            if (state == CMD && last_rise) begin
               rd_flag   <= cmd_rd | fast_ok;
               fast_flag <= fast_ok;
            end

            if (state == ADDR && last_rise) begin
               addr <= shift_nx;
               re_r <= rd_flag;
            end

            if (state == RDATA && sclk_fall) begin
               oe_r   <= 1'b1;
               miso_r <= byte_cur[7];
               tx_sr  <= {byte_cur[6:0], 1'b0};
            end else if (cap_pend) begin
               tx_sr <= mem_rdata;
            end

            if (state == RDATA && last_rise) begin
               addr <= addr + MEM_AW'(1);
               re_r <= 1'b1;
            end

            if (state == WDATA && last_rise) begin
               wdata_r <= shift_nx[7:0];
               wr_step <= 1'b1;
            end

            // Write strobe goes out at the current address; step afterwards.
            if (wr_step) addr <= addr + MEM_AW'(1);
         end
      end
   end

   // Outputs
   always_comb begin
      spi_miso    = miso_r;
      spi_miso_oe = oe_r;
      mem_addr    = addr;
      mem_wdata   = wdata_r;
      mem_we      = wr_step && (READ_ONLY == 0);
      mem_re      = re_r;
      busy        = ~cs_s;
   end

endmodule

// File: tb/tb_spi_mem_target.sv
// Self-checking bench for spi_mem_target: dut0 is read/write, dut1 is
// READ_ONLY. Both share sclk/mosi and have separate chip selects.
module tb_spi_mem_target;

   localparam int AW   = 16;
   localparam int HALF = 50;   // sclk half period: 5 clk

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic cs0_n = 1'b1, cs1_n = 1'b1, sclk = 1'b0, mosi = 1'b0;
   logic miso0, oe0, we0, re0, busy0, miso1, oe1, we1, re1, busy1;
   logic [AW-1:0] addr0, addr1;
   logic [7:0]    wdata0, wdata1, rdata0, rdata1;

   always #5 clk = ~clk;

   spi_mem_target #(.MEM_AW(AW), .READ_ONLY(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .spi_cs_n(cs0_n), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_miso(miso0), .spi_miso_oe(oe0), .mem_addr(addr0), .mem_wdata(wdata0),
      .mem_we(we0), .mem_re(re0), .mem_rdata(rdata0), .busy(busy0));

   spi_mem_target #(.MEM_AW(AW), .READ_ONLY(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .spi_cs_n(cs1_n), .spi_sclk(sclk), .spi_mosi(mosi),
      .spi_miso(miso1), .spi_miso_oe(oe1), .mem_addr(addr1), .mem_wdata(wdata1),
      .mem_we(we1), .mem_re(re1), .mem_rdata(rdata1), .busy(busy1));

   int n_tests = 0;
   int n_fail  = 0;

   // Unwritten memory locations hold a fixed function of their address.
   function automatic logic [7:0] init_val(input int unsigned a);
      return 8'(a * 37 + 11);
   endfunction

   // Environment memories and bus monitors
   logic [7:0]  mem0 [int];
   logic [7:0]  mem1 [int];
   int unsigned we_q0[$], re_q0[$], we_q1[$], re_q1[$];
   int          oe_cnt0 = 0, oe_cnt1 = 0, clash_cnt = 0;

   always @(posedge clk) begin
      if (we0) begin mem0[int'(addr0)] = wdata0; we_q0.push_back(32'({addr0, wdata0})); end
      if (re0) begin
         rdata0 <= mem0.exists(int'(addr0)) ? mem0[int'(addr0)] : init_val(32'(addr0));
         re_q0.push_back(32'(addr0));
      end
      if (we1) begin mem1[int'(addr1)] = wdata1; we_q1.push_back(32'({addr1, wdata1})); end
      if (re1) begin
         rdata1 <= mem1.exists(int'(addr1)) ? mem1[int'(addr1)] : init_val(32'(addr1));
         re_q1.push_back(32'(addr1));
      end
      if (oe0) oe_cnt0++;
      if (oe1) oe_cnt1++;
      if ((we0 && re0) || (we1 && re1)) clash_cnt++;
   end

   // Reference model: byte-addressed memory image plus expected bus activity
   logic [7:0]  ref0 [int];
   logic [7:0]  txb[$], rxb[$], data_q[$], exp_rx[$];
   int unsigned exp_we[$], exp_re[$];
   int          wb0, rb0, ob0, wb1, rb1, ob1, busy_lat;
   logic        busy_mid;

   function automatic logic [7:0] ref_rd(input int sel, input int unsigned a);
      if (sel == 0 && ref0.exists(int'(a))) return ref0[int'(a)];
      return init_val(a);
   endfunction

   task automatic push_hdr(input logic [7:0] cmd, input int unsigned a);
      txb.delete(); exp_we.delete(); exp_re.delete(); exp_rx.delete();
      txb.push_back(cmd);
      txb.push_back(8'(a >> 16));
      txb.push_back(8'(a >> 8));
      txb.push_back(8'(a));
   endtask

   // WRITE of data_q at SPI address a; the read-only target (sel 1) writes nothing.
   task automatic plan_write(input int sel, input int unsigned a);
      int unsigned ad;
      push_hdr(8'h02, a);
      foreach (data_q[i]) begin
         ad = (a + i) % 65536;
         txb.push_back(data_q[i]);
         if (sel == 0) begin
            exp_we.push_back(ad * 256 + data_q[i]);
            ref0[int'(ad)] = data_q[i];
         end
      end
   endtask

   // READ/FAST READ of n bytes: the target fetches n+1 consecutive addresses.
   task automatic plan_read(input int sel, input int unsigned a, input int n,
                            input logic [7:0] cmd, input int dummy);
      push_hdr(cmd, a);
      for (int i = 0; i < dummy + n; i++) txb.push_back(8'($urandom));
      for (int i = 0; i < n; i++) exp_rx.push_back(ref_rd(sel, (a + i) % 65536));
      for (int i = 0; i <= n; i++) exp_re.push_back((a + i) % 65536);
   endtask

   // Clock out txb (plus 'tail' stray bits) with the selected chip select low.
   task automatic spi_txn(input int sel, input int tail);
      logic [7:0] r;
      wb0 = we_q0.size(); rb0 = re_q0.size(); ob0 = oe_cnt0;
      wb1 = we_q1.size(); rb1 = re_q1.size(); ob1 = oe_cnt1;
      rxb.delete();
      r = '0;
      @(negedge clk);
      if (sel == 0) cs0_n = 1'b0; else cs1_n = 1'b0;
      #(HALF);
      foreach (txb[k]) begin
         for (int i = 7; i >= 0; i--) begin
            mosi = txb[k][i];
            #(HALF); sclk = 1'b1;
            r[i] = (sel == 0) ? miso0 : miso1;
            #(HALF); sclk = 1'b0;
         end
         rxb.push_back(r);
      end
      for (int i = 0; i < tail; i++) begin
         mosi = 1'($urandom_range(0, 1));
         #(HALF); sclk = 1'b1;
         #(HALF); sclk = 1'b0;
      end
      #(HALF);
      busy_mid = (sel == 0) ? busy0 : busy1;
      cs0_n = 1'b1; cs1_n = 1'b1;
      busy_lat = 99;
      for (int c = 1; c <= 8; c++) begin
         @(posedge clk); #1;
         if (((sel == 0) ? busy0 : busy1) == 1'b0) begin busy_lat = c; break; end
      end
      repeat (4) @(posedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({miso0, oe0, we0, re0, busy0} !== 5'b0) begin
         n_fail++; $display("FAIL reset_ctl0: got %b want 00000", {miso0, oe0, we0, re0, busy0});
      end
      n_tests++;
      if ({addr0, wdata0} !== 24'h0) begin
         n_fail++; $display("FAIL reset_bus0: got %h want 000000", {addr0, wdata0});
      end
      n_tests++;
      if ({miso1, oe1, we1, re1, busy1, addr1, wdata1} !== 29'h0) begin
         n_fail++; $display("FAIL reset_dut1: got %h want 0", {miso1, oe1, we1, re1, busy1, addr1, wdata1});
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      n_tests++;
      if ({busy0, oe0, we0, re0} !== 4'b0) begin
         n_fail++; $display("FAIL idle_after_reset: got %b want 0000", {busy0, oe0, we0, re0});
      end
   endtask

   task automatic test_write_burst;
      data_q = '{8'hA5, 8'h3C};
      plan_write(0, 32'h000010);
      spi_txn(0, 0);
      n_tests++;
      if (we_q0.size() - wb0 !== exp_we.size()) begin
         n_fail++; $display("FAIL wr_burst_count: got %0d want %0d", we_q0.size() - wb0, exp_we.size());
      end
      foreach (exp_we[i]) begin
         n_tests++;
         if (wb0 + i >= we_q0.size() || we_q0[wb0 + i] !== exp_we[i]) begin
            n_fail++; $display("FAIL wr_burst_%0d: got %h want %h", i,
                               (wb0 + i < we_q0.size()) ? we_q0[wb0 + i] : 32'hX, exp_we[i]);
         end
      end
      n_tests++;
      if (busy_mid !== 1'b1) begin n_fail++; $display("FAIL busy_during_txn: got %b want 1", busy_mid); end
   endtask

   task automatic test_read_burst;
      plan_read(0, 32'h000010, 2, 8'h03, 0);
      spi_txn(0, 0);
      foreach (exp_rx[i]) begin
         n_tests++;
         if (rxb[4 + i] !== exp_rx[i]) begin
            n_fail++; $display("FAIL rd_burst_byte%0d: got %h want %h", i, rxb[4 + i], exp_rx[i]);
         end
      end
      n_tests++;
      if (re_q0.size() - rb0 !== exp_re.size()) begin
         n_fail++; $display("FAIL rd_burst_re_count: got %0d want %0d", re_q0.size() - rb0, exp_re.size());
      end
      foreach (exp_re[i]) begin
         n_tests++;
         if (rb0 + i >= re_q0.size() || re_q0[rb0 + i] !== exp_re[i]) begin
            n_fail++; $display("FAIL rd_burst_re%0d: got %h want %h", i,
                               (rb0 + i < re_q0.size()) ? re_q0[rb0 + i] : 32'hX, exp_re[i]);
         end
      end
      n_tests++;
      if (oe_cnt0 - ob0 == 0) begin n_fail++; $display("FAIL rd_burst_oe: got 0 cycles want >0"); end
   endtask

   task automatic test_unknown_cmd;
      push_hdr(8'h9F, 32'h000010);
      for (int i = 0; i < 3; i++) txb.push_back(8'($urandom));
      spi_txn(0, 0);
      n_tests++;
      if ((oe_cnt0 - ob0) + (re_q0.size() - rb0) + (we_q0.size() - wb0) !== 0) begin
         n_fail++; $display("FAIL unknown_9f: got oe=%0d re=%0d we=%0d want all 0",
                            oe_cnt0 - ob0, re_q0.size() - rb0, we_q0.size() - wb0);
      end
`ifdef SPI_TGT_FAST_READ_EN
      plan_read(0, 32'h000010, 1, 8'h0B, 1);
      spi_txn(0, 0);
      n_tests++;
      if (rxb[5] !== exp_rx[0]) begin
         n_fail++; $display("FAIL fast_read_byte: got %h want %h", rxb[5], exp_rx[0]);
      end
      n_tests++;
      if (re_q0.size() - rb0 !== 2 || re_q0[rb0] !== exp_re[0]) begin
         n_fail++; $display("FAIL fast_read_re: got %0d strobes want 2 from %h", re_q0.size() - rb0, exp_re[0]);
      end
`else
      push_hdr(8'h0B, 32'h000010);
      for (int i = 0; i < 2; i++) txb.push_back(8'($urandom));
      spi_txn(0, 0);
      n_tests++;
      if ((oe_cnt0 - ob0) + (re_q0.size() - rb0) !== 0) begin
         n_fail++; $display("FAIL fast_read_disabled: got oe=%0d re=%0d want 0 0", oe_cnt0 - ob0, re_q0.size() - rb0);
      end
`endif
   endtask

   task automatic test_abort;
      data_q.delete();
      plan_write(0, 32'h000020);
      spi_txn(0, 5);
      n_tests++;
      if (we_q0.size() - wb0 !== 0) begin
         n_fail++; $display("FAIL abort_we: got %0d strobes want 0", we_q0.size() - wb0);
      end
      n_tests++;
      if (busy_lat > 3) begin n_fail++; $display("FAIL abort_busy_latency: got %0d clk want <=3", busy_lat); end
      plan_read(0, 32'h000020, 1, 8'h03, 0);
      spi_txn(0, 0);
      n_tests++;
      if (rxb[4] !== exp_rx[0]) begin
         n_fail++; $display("FAIL read_after_abort: got %h want %h", rxb[4], exp_rx[0]);
      end
   endtask

   task automatic test_wrap_read_only;
      data_q = '{8'h5A, 8'hC3};
      plan_write(1, 32'h00FFFF);
      spi_txn(1, 0);
      n_tests++;
      if (we_q1.size() - wb1 !== 0) begin
         n_fail++; $display("FAIL ro_write_we: got %0d strobes want 0", we_q1.size() - wb1);
      end
      plan_read(1, 32'h00FFFF, 2, 8'h03, 0);
      spi_txn(1, 0);
      foreach (exp_re[i]) begin
         n_tests++;
         if (rb1 + i >= re_q1.size() || re_q1[rb1 + i] !== exp_re[i]) begin
            n_fail++; $display("FAIL ro_wrap_re%0d: got %h want %h", i,
                               (rb1 + i < re_q1.size()) ? re_q1[rb1 + i] : 32'hX, exp_re[i]);
         end
      end
      n_tests++;
      if ({rxb[4], rxb[5]} !== {exp_rx[0], exp_rx[1]}) begin
         n_fail++; $display("FAIL ro_wrap_data: got %h%h want %h%h", rxb[4], rxb[5], exp_rx[0], exp_rx[1]);
      end
      // Writable target across the wrap, upper SPI address bits ignored
      data_q = '{8'h11, 8'h22};
      plan_write(0, 32'h12FFFF);
      spi_txn(0, 0);
      n_tests++;
      if (we_q0.size() - wb0 !== 2 || we_q0[wb0] !== exp_we[0] || we_q0[wb0 + 1] !== exp_we[1]) begin
         n_fail++; $display("FAIL wrap_write: got %0d strobes want %h %h", we_q0.size() - wb0, exp_we[0], exp_we[1]);
      end
   endtask

   task automatic test_random_bursts;
      int unsigned a;
      int n;
      for (int it = 0; it < 8; it++) begin
         a = $urandom & 32'hFFFFFF;
         if ($urandom_range(0, 2) == 0) a = (a & 32'hFF0000) | (32'hFFFF - $urandom_range(0, 2));
         n = $urandom_range(1, 4);
         if ($urandom_range(0, 1) == 1) begin
            data_q.delete();
            for (int i = 0; i < n; i++) data_q.push_back(8'($urandom));
            plan_write(0, a);
            spi_txn(0, 0);
            n_tests++;
            if (we_q0.size() - wb0 !== exp_we.size()) begin
               n_fail++; $display("FAIL rand%0d_we_count: got %0d want %0d", it, we_q0.size() - wb0, exp_we.size());
            end
            foreach (exp_we[i]) begin
               n_tests++;
               if (wb0 + i >= we_q0.size() || we_q0[wb0 + i] !== exp_we[i]) begin
                  n_fail++; $display("FAIL rand%0d_we%0d: got %h want %h", it, i,
                                     (wb0 + i < we_q0.size()) ? we_q0[wb0 + i] : 32'hX, exp_we[i]);
               end
            end
         end else begin
            plan_read(0, a, n, 8'h03, 0);
            spi_txn(0, 0);
            foreach (exp_rx[i]) begin
               n_tests++;
               if (rxb[4 + i] !== exp_rx[i]) begin
                  n_fail++; $display("FAIL rand%0d_rx%0d: got %h want %h", it, i, rxb[4 + i], exp_rx[i]);
               end
            end
            n_tests++;
            if (re_q0.size() - rb0 !== exp_re.size() || re_q0[rb0] !== exp_re[0]) begin
               n_fail++; $display("FAIL rand%0d_re: got %0d strobes want %0d from %h", it,
                                  re_q0.size() - rb0, exp_re.size(), exp_re[0]);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      int unsigned a;
      a = $urandom & 32'hFFFFFF;
      data_q = '{8'($urandom), 8'($urandom), 8'($urandom)};
      plan_write(0, a);
      spi_txn(0, 0);
      plan_read(0, a, 3, 8'h03, 0);
      spi_txn(0, 0);
      n_tests++;
      if ({rxb[4], rxb[5], rxb[6]} !== {data_q[0], data_q[1], data_q[2]}) begin
         n_fail++; $display("FAIL write_readback: got %h%h%h want %h%h%h",
                            rxb[4], rxb[5], rxb[6], data_q[0], data_q[1], data_q[2]);
      end
      n_tests++;
      if (clash_cnt !== 0) begin n_fail++; $display("FAIL we_re_clash: got %0d cycles want 0", clash_cnt); end
   endtask

   initial begin
      test_reset;
      test_write_burst;
      test_read_burst;
      test_unknown_cmd;
      test_abort;
      test_wrap_read_only;
      test_random_bursts;
      test_back_to_back;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
